// File: rtl/ssd1306_vga_scan.sv
// ssd1306_vga_scan: scans a 128x64 SSD1306 page-organised framebuffer out as
// 640x480@60 VGA timing. Each OLED pixel becomes a 4x4 block and the 512x256
// image is centred in the raster. A two-stage pipeline on ce_pix fetches the
// framebuffer byte in stage 0 and resolves the pixel in stage 1.
`timescale 1ns/1ps

module ssd1306_vga_scan #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int H_OFS    = 64,
    parameter int V_OFS    = 112
) (
    input  logic       clk_100m,
    input  logic       reset,
    input  logic       ce_pix,
    input  logic       display_on,
    input  logic       invert,
    output logic [9:0] fb_addr,
    input  logic [7:0] fb_data,
    output logic       hsync,
    output logic       vsync,
    output logic       hblank,
    output logic       vblank,
    output logic       pixelValue,
    output logic       frame_start
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam int WIN_W    = 512;
    localparam int WIN_H    = 256;

    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       h_last;
    logic       v_last;

    // Raster-position terms decoded from the live counters
    logic       in_win;
    logic [6:0] col;
    logic [5:0] row;
    logic       hs_term;
    logic       vs_term;
    logic       hb_term;
    logic       vb_term;
    logic       frame_term;

    // Stage-0 copies, aligned with fb_addr
    logic       win_p0;
    logic [2:0] row_p0;
    logic       hsync_p0;
    logic       vsync_p0;
    logic       hblank_p0;
    logic       vblank_p0;
    logic       frame_p0;

    assign h_last = (h_cnt == 10'(H_TOTAL - 1));
    assign v_last = (v_cnt == 10'(V_TOTAL - 1));

    // Counters advance one pixel per ce_pix; the line counter steps on line wrap
    always_ff @(posedge clk_100m or posedge reset) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (ce_pix) begin
            if (h_last) begin
                h_cnt <= '0;
                v_cnt <= v_last ? 10'd0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    // Window, sync and blank decode for the pixel the counters currently present
    always_comb begin
        in_win     = (h_cnt >= 10'(H_OFS)) && (h_cnt < 10'(H_OFS + WIN_W)) &&
                     (v_cnt >= 10'(V_OFS)) && (v_cnt < 10'(V_OFS + WIN_H));
        col        = 7'((h_cnt - 10'(H_OFS)) >> 2);
        row        = 6'((v_cnt - 10'(V_OFS)) >> 2);
        hs_term    = (h_cnt >= 10'(HS_START)) && (h_cnt < 10'(HS_END));
        vs_term    = (v_cnt >= 10'(VS_START)) && (v_cnt < 10'(VS_END));
        hb_term    = (h_cnt >= 10'(H_ACTIVE));
        vb_term    = (v_cnt >= 10'(V_ACTIVE));
        frame_term = (h_cnt == 10'd0) && (v_cnt == 10'd0);
    end

    // ---- stage 0: issue the framebuffer read and capture the timing terms ----
    // Blank copies idle high so the outputs keep their reset values until the
    // first real pixel reaches stage 1; fb_addr holds outside the window.
    always_ff @(posedge clk_100m or posedge reset) begin
        if (reset) begin
            fb_addr   <= '0;
            win_p0    <= 1'b0;
            row_p0    <= '0;
            hsync_p0  <= 1'b0;
            vsync_p0  <= 1'b0;
            hblank_p0 <= 1'b1;
            vblank_p0 <= 1'b1;
            frame_p0  <= 1'b0;
        end else if (ce_pix) begin
            if (in_win) begin
                fb_addr <= {row[5:3], col};
            end
            win_p0    <= in_win;
            row_p0    <= row[2:0];
            hsync_p0  <= hs_term;
            vsync_p0  <= vs_term;
            hblank_p0 <= hb_term;
            vblank_p0 <= vb_term;
            frame_p0  <= frame_term;
        end
    end

    // ---- stage 1: select the bit for this line of the page and register outputs ----
    // Bit 0 of a byte is the top line of its page; the border stays black.
    always_ff @(posedge clk_100m or posedge reset) begin
        if (reset) begin
            hsync      <= 1'b0;
            vsync      <= 1'b0;
            hblank     <= 1'b1;
            vblank     <= 1'b1;
            pixelValue <= 1'b0;
        end else if (ce_pix) begin
            hsync      <= hsync_p0;
            vsync      <= vsync_p0;
            hblank     <= hblank_p0;
            vblank     <= vblank_p0;
            pixelValue <= win_p0 & display_on & (fb_data[row_p0] ^ invert);
        end
    end

    // frame_start is a single clk_100m strobe on the ce_pix that outputs pixel (0,0)
    always_ff @(posedge clk_100m or posedge reset) begin
        if (reset) begin
            frame_start <= 1'b0;
        end else begin
            frame_start <= ce_pix & frame_p0;
        end
    end

endmodule

// File: tb/tb_ssd1306_vga_scan.sv
// Bench for ssd1306_vga_scan: horizontal timing at its real values, vertical
// timing shrunk to an 8-line frame with the image window starting on line 1
// so whole frames fit in a short run.
`timescale 1ns/1ps

module tb_ssd1306_vga_scan;

    localparam int HT   = 800;
    localparam int VA   = 4;
    localparam int VF   = 1;
    localparam int VS   = 2;
    localparam int VB   = 1;
    localparam int VT   = VA + VF + VS + VB;
    localparam int VOFS = 1;

    logic       clk_100m = 1'b0;
    logic       reset = 1'b1;
    logic       ce_pix = 1'b0;
    logic       display_on = 1'b1;
    logic       invert = 1'b0;
    logic [9:0] fb_addr;
    logic [7:0] fb_data;
    logic       hsync, vsync, hblank, vblank, pixelValue, frame_start;

    logic [7:0] fb_mem [0:1023];

    ssd1306_vga_scan #(
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .V_OFS(VOFS)
    ) dut (
        .clk_100m(clk_100m), .reset(reset), .ce_pix(ce_pix),
        .display_on(display_on), .invert(invert),
        .fb_addr(fb_addr), .fb_data(fb_data),
        .hsync(hsync), .vsync(vsync), .hblank(hblank), .vblank(vblank),
        .pixelValue(pixelValue), .frame_start(frame_start)
    );

    always #5 clk_100m = ~clk_100m;

    // Synchronous RAM read port, one clock of latency
    always @(posedge clk_100m) fb_data <= fb_mem[fb_addr];

    int n_vec = 0;
    int n_bad = 0;
    int n_ce = 0;
    int idle_glitch = 0;
    int fs_hi = 0;
    bit last_fs;

    always @(negedge clk_100m) if (frame_start === 1'b1) fs_hi++;

    typedef struct {
        int         fbm;
        bit         don;
        bit         inv;
        int         h;
        int         v;
        logic [4:0] exp;   // {hsync, vsync, hblank, vblank, pixelValue}
        int         addr;  // expected fb_addr, -1 = not checked
    } vec_t;

    vec_t tbl[$];

    function automatic logic [4:0] outs();
        return {hsync, vsync, hblank, vblank, pixelValue};
    endfunction

    function automatic vec_t mk(int fbm, bit don, bit inv, int h, int v,
                                logic [4:0] exp, int addr);
        vec_t x;
        x.fbm = fbm; x.don = don; x.inv = inv; x.h = h; x.v = v;
        x.exp = exp; x.addr = addr;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Framebuffer patterns: 0 all clear, 1 all set, 2 byte 0x000=0x01,
    // 3 byte 0x07F=0x01, 4 byte 0x005=0x02
    task automatic fill_fb(input int mode);
        for (int i = 0; i < 1024; i++) fb_mem[i] = (mode == 1) ? 8'hFF : 8'h00;
        if (mode == 2) fb_mem[0]      = 8'h01;
        if (mode == 3) fb_mem[10'h07F] = 8'h01;
        if (mode == 4) fb_mem[5]      = 8'h02;
    endtask

    // One pixel period: ce_pix for one clock, then three idle clocks in which
    // nothing the DUT drives may move
    task automatic tick_ce();
        logic [14:0] snap;
        ce_pix = 1'b1;
        @(posedge clk_100m); #1;
        ce_pix = 1'b0;
        n_ce++;
        last_fs = frame_start;
        snap = {outs(), fb_addr};
        repeat (3) begin
            @(posedge clk_100m); #1;
            if ({outs(), fb_addr} !== snap || frame_start !== 1'b0) idle_glitch++;
        end
    endtask

    // Step until the outputs present counter position (h, v); the outputs of
    // ce number n show the pixel the counters held at ce number n-1.
    task automatic advance_to(input int h, input int v);
        int cur, t;
        cur = n_ce - 2;
        t = v * HT + h;
        if (cur > 0) t += cur - (cur % (HT * VT));
        if (t < cur) t += HT * VT;
        while (n_ce - 2 < t) tick_ce();
    endtask

    task automatic run_vec(input vec_t x);
        fill_fb(x.fbm);
        display_on = x.don;
        invert = x.inv;
        advance_to(x.h, x.v);
        check($sformatf("outs m%0d d%0d i%0d h%0d v%0d", x.fbm, x.don, x.inv, x.h, x.v),
              32'(outs()), 32'(x.exp));
        if (x.addr >= 0)
            check($sformatf("fb_addr h%0d v%0d", x.h, x.v), 32'(fb_addr), x.addr);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int hs_cnt, hb_low, first_hs, vb_low_lines, vs_lines, first_vs, px_cnt;
        int p, h, v, k, hold_chg;
        bit fs1, fs2;
        logic [15:0] snap;

        fill_fb(1);
        tbl.push_back(mk(1, 1, 0,   0, 0, 5'b00000,  -1));
        tbl.push_back(mk(1, 1, 0, 700, 0, 5'b10100,  -1));
        tbl.push_back(mk(1, 1, 0,  63, 1, 5'b00000,   0));
        tbl.push_back(mk(1, 1, 0,  64, 1, 5'b00001,   0));
        tbl.push_back(mk(1, 1, 0, 575, 1, 5'b00001, 127));
        tbl.push_back(mk(1, 1, 0, 576, 1, 5'b00000, 127));
        tbl.push_back(mk(1, 1, 0, 639, 1, 5'b00000,  -1));
        tbl.push_back(mk(1, 1, 0, 640, 1, 5'b00100,  -1));
        tbl.push_back(mk(1, 1, 0, 655, 1, 5'b00100,  -1));
        tbl.push_back(mk(1, 1, 0, 656, 1, 5'b10100,  -1));
        tbl.push_back(mk(1, 1, 0, 751, 1, 5'b10100,  -1));
        tbl.push_back(mk(1, 1, 0, 752, 1, 5'b00100,  -1));
        tbl.push_back(mk(1, 1, 1,  20, 2, 5'b00000, 127));
        tbl.push_back(mk(1, 1, 1,  64, 2, 5'b00000,  -1));
        tbl.push_back(mk(0, 1, 1, 300, 2, 5'b00001,  59));
        tbl.push_back(mk(0, 1, 1, 600, 2, 5'b00000,  -1));
        tbl.push_back(mk(3, 1, 0, 571, 3, 5'b00000,  -1));
        tbl.push_back(mk(3, 1, 0, 572, 3, 5'b00001,  -1));
        tbl.push_back(mk(3, 1, 0, 575, 3, 5'b00001,  -1));
        tbl.push_back(mk(3, 1, 0, 576, 3, 5'b00000,  -1));
        tbl.push_back(mk(2, 1, 0,  63, 4, 5'b00010,  -1));
        tbl.push_back(mk(2, 1, 0,  64, 4, 5'b00011,   0));
        tbl.push_back(mk(2, 1, 0,  67, 4, 5'b00011,  -1));
        tbl.push_back(mk(2, 1, 0,  68, 4, 5'b00010,  -1));
        tbl.push_back(mk(1, 0, 0, 300, 4, 5'b00010,  -1));
        tbl.push_back(mk(1, 0, 0, 700, 4, 5'b10110,  -1));
        tbl.push_back(mk(4, 1, 0,  83, 5, 5'b01010,  -1));
        tbl.push_back(mk(4, 1, 0,  84, 5, 5'b01011,   5));
        tbl.push_back(mk(4, 1, 0,  87, 5, 5'b01011,   6));
        tbl.push_back(mk(4, 1, 0,  88, 5, 5'b01010,  -1));
        tbl.push_back(mk(2, 1, 0,  64, 6, 5'b01010,  -1));
        tbl.push_back(mk(1, 0, 1, 200, 6, 5'b01010,  -1));
        tbl.push_back(mk(1, 1, 0, 100, 7, 5'b00011,  -1));

        // Reset state
        repeat (3) @(posedge clk_100m);
        #1;
        check("reset_outs", 32'({outs(), frame_start}), 32'(6'b001100));
        check("reset_fb_addr", 32'(fb_addr), 0);
        reset = 1'b0;

        // Whole first frame, all pixels lit: timing and pixel statistics
        hs_cnt = 0; hb_low = 0; first_hs = -1; vb_low_lines = 0;
        vs_lines = 0; first_vs = -1; px_cnt = 0; fs_hi = 0; fs1 = 0; fs2 = 0;
        for (int n = 1; n <= HT * VT + 1; n++) begin
            tick_ce();
            if (n == 1) fs1 = last_fs;
            if (n == 2) fs2 = last_fs;
            p = n_ce - 2;
            if (p >= 0 && p < HT * VT) begin
                h = p % HT;
                v = p / HT;
                if (v == 1) begin
                    hs_cnt += int'(hsync);
                    hb_low += int'(!hblank);
                    if (hsync && first_hs < 0) first_hs = n_ce - (HT * v + 1);
                end
                if (h == 0) begin
                    vb_low_lines += int'(!vblank);
                    if (vsync) begin
                        vs_lines++;
                        if (first_vs < 0) first_vs = v;
                    end
                end
                px_cnt += int'(pixelValue);
            end
        end
        check("first_frame_start_ce", 32'({fs1, fs2}), 32'(2'b01));
        check("frame_start_clks_per_frame", fs_hi, 1);
        check("hsync_ce_per_line", hs_cnt, 96);
        check("hsync_start_ce", first_hs, 657);
        check("hblank_low_per_line", hb_low, 640);
        check("vblank_low_lines", vb_low_lines, VA);
        check("vsync_lines", vs_lines, VS);
        check("vsync_first_line", first_vs, VA + VF);
        check("lit_pixels_per_frame", px_cnt, 512 * (VT - VOFS));

        // Directed vectors across the second frame
        foreach (tbl[i]) run_vec(tbl[i]);

        // Asynchronous reset in the middle of a visible line
        run_vec(mk(1, 1, 0, 299, 7, 5'b00011, -1));
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_outs", 32'({outs(), frame_start}), 32'(6'b001100));
        check("async_reset_fb_addr", 32'(fb_addr), 0);
        @(posedge clk_100m);
        @(posedge clk_100m);
        #1;
        reset = 1'b0;
        n_ce = 0;
        k = 0; fs1 = 0; fs2 = 0;
        while (hsync !== 1'b1 && k < 1000) begin
            tick_ce();
            k++;
            if (k == 1) fs1 = last_fs;
            if (k == 2) fs2 = last_fs;
        end
        check("restart_frame_start_ce", 32'({fs1, fs2}), 32'(2'b01));
        check("restart_hsync_start_ce", n_ce - 1, 657);

        // ce_pix held low for 50 clocks in the middle of the sync pulse
        snap = {outs(), fb_addr, frame_start};
        hold_chg = 0;
        repeat (50) begin
            @(posedge clk_100m); #1;
            if ({outs(), fb_addr, frame_start} !== snap) hold_chg++;
        end
        check("ce_hold_changes", hold_chg, 0);
        run_vec(mk(1, 1, 0, 751, 0, 5'b10100, -1));
        run_vec(mk(1, 1, 0, 752, 0, 5'b00100, -1));

        check("idle_clock_changes", idle_glitch, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
